// File: rtl/sha256_ctrl.sv
// Sequencing controller for the SHA-256 datapath: block load, compression rounds, hash add, digest handshake.
// Optional double hashing is enabled with SHA256_CTRL_DOUBLE_HASH_EN (adds the ld_digest output).
module sha256_ctrl #(
    parameter int MAX_BLOCKS = 2,
    parameter int ROUNDS     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    input  logic [1:0] msg_blocks,
    output logic       msg_ready,
    output logic       digest_valid,
    input  logic       digest_ready,
    output logic       ld_iv,
    output logic       ld_block,
    output logic [1:0] blk_sel,
    output logic       round_en,
    output logic [5:0] round_idx,
    output logic       sched_en,
    output logic       add_en,
    output logic       busy,
    output logic       len_err
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
    ,
    output logic       ld_digest
`endif
);

    localparam logic [1:0] MAX_B    = 2'(MAX_BLOCKS);
    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] nblk_q, nblk_d;
    logic [1:0] blk_sel_q, blk_sel_d;
    logic [5:0] round_q, round_d;
    logic       len_err_q, len_err_d;
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
    logic       pass_q, pass_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            nblk_q    <= 2'd1;
            blk_sel_q <= '0;
            round_q   <= '0;
            len_err_q <= 1'b0;
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nblk_q    <= nblk_d;
            blk_sel_q <= blk_sel_d;
            round_q   <= round_d;
            len_err_q <= len_err_d;
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
            pass_q    <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        nblk_d    = nblk_q;
        blk_sel_d = blk_sel_q;
        round_d   = round_q;
        len_err_d = 1'b0;
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
        pass_d    = pass_q;
`endif
        case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    state_d   = LOAD;
                    blk_sel_d = '0;
                    round_d   = '0;
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
                    pass_d    = 1'b0;
`endif
                    // len_err is registered, so the clamp pulse is seen in the LOAD cycle after accept
                    if (msg_blocks == 2'd0) begin
                        nblk_d    = 2'd1;
                        len_err_d = 1'b1;
                    end else if (msg_blocks > MAX_B) begin
                        nblk_d    = MAX_B;
                        len_err_d = 1'b1;
                    end else begin
                        nblk_d    = msg_blocks;
                    end
                end
            end
            LOAD: begin
                state_d = ROUND;
                round_d = '0;
            end
            ROUND: begin
                if (round_q == LAST_RND) begin
                    state_d = ADD;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            ADD: begin
                if ({1'b0, blk_sel_q} + 3'd1 < {1'b0, nblk_q}) begin
                    blk_sel_d = blk_sel_q + 2'd1;
                    state_d   = LOAD;
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
                end else if (!pass_q) begin
                    pass_d    = 1'b1;
                    blk_sel_d = '0;
                    state_d   = LOAD;
`endif
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (digest_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign msg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign ld_iv        = (state_q == LOAD) && (blk_sel_q == 2'd0);
`ifdef SHA256_CTRL_DOUBLE_HASH_EN
    assign ld_block     = (state_q == LOAD) && !pass_q;
    assign ld_digest    = (state_q == LOAD) && pass_q;
`else
    assign ld_block     = (state_q == LOAD);
`endif
    assign round_en     = (state_q == ROUND);
    assign sched_en     = (state_q == ROUND) && (round_q >= 6'd16);
    assign add_en       = (state_q == ADD);
    assign digest_valid = (state_q == DONE);
    assign blk_sel      = blk_sel_q;
    assign round_idx    = round_q;
    assign len_err      = len_err_q;

endmodule
